// File: rtl/fact_sched.sv
// Round-robin scheduler sharing one factorial engine between NREQ requesters.
// req sampled in IDLE -> fact_go next cycle; fact_done sampled -> ack next cycle; watchdog aborts a silent engine.
module fact_sched #(
    parameter int NREQ    = 4,
    parameter int NW      = 4,
    parameter int SIZE    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*NW-1:0]        n_in,
    output logic                      fact_go,
    output logic [NW-1:0]             fact_n,
    input  logic                      fact_done,
    input  logic [SIZE-1:0]           fact_result,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy,
    output logic [NREQ-1:0]           ack,
    output logic [SIZE-1:0]           result,
    output logic                      err
);

    localparam int IDW = $clog2(NREQ);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX   = TW'(TIMEOUT);
    localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  ptr;
    logic [TW-1:0]   timer;
    logic [IDW-1:0]  winner;
    logic            found;
    int              idx;
    logic            timeout_hit;

    // Scan starts just after the last-served requester, so it has lowest priority.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    assign timeout_hit = (timer == TLIMIT);

    always_comb begin
        state_nxt = state;
        fact_go   = 1'b0;
        busy      = 1'b1;
        ack       = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (found) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                fact_go   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (fact_done || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                ack[grant_id] = 1'b1;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= IDW'(NREQ - 1);
            timer    <= '0;
            grant_id <= '0;
            fact_n   <= '0;
            result   <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id <= winner;
                        fact_n   <= n_in[winner*NW +: NW];
                    end
                end
                ISSUE: begin
                    timer <= '0;
                end
                WAIT: begin
                    if (timer != TMAX) begin
                        timer <= timer + 1'b1;
                    end
                    // A completion on the watchdog cycle still counts as success.
                    if (fact_done) begin
                        result <= fact_result;
                        err    <= 1'b0;
                    end else if (timeout_hit) begin
                        result <= '0;
                        err    <= 1'b1;
                    end
                end
                RESP: begin
                    ptr <= grant_id;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fact_sched.sv
// Directed bench for fact_sched: scoreboard of expected acks plus an engine model.
module tb_fact_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] n_in;
    logic        fact_go;
    logic [3:0]  fact_n;
    logic        fact_done;
    logic [7:0]  fact_result;
    logic [1:0]  grant_id;
    logic        busy;
    logic [3:0]  ack;
    logic [7:0]  result;
    logic        err;

    fact_sched #(.NREQ(4), .NW(4), .SIZE(8), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .req(req), .n_in(n_in),
        .fact_go(fact_go), .fact_n(fact_n), .fact_done(fact_done),
        .fact_result(fact_result), .grant_id(grant_id), .busy(busy),
        .ack(ack), .result(result), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int res;
        int er;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   errs  = 0;
    int   cyc   = 0;
    bit   eng_on;
    int   eng_delay;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        tests++;
        errs++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic push(input int id, input int res, input int er);
        exp_t e;
        e.id  = id;
        e.res = res;
        e.er  = er;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int lim, output int at);
        at = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) fail_bound("ack_wait");
    endtask

    // Hand table of n! for the operands used below.
    function automatic int fact_of(input logic [3:0] n);
        case (n)
            4'd0, 4'd1: return 1;
            4'd2:       return 2;
            4'd3:       return 6;
            4'd4:       return 24;
            4'd5:       return 120;
            default:    return 0;
        endcase
    endfunction

    initial forever @(posedge clk) cyc = cyc + 1;

    // Engine model: answers fact_go after eng_delay cycles unless disabled.
    initial begin
        int n;
        fact_done   = 1'b0;
        fact_result = 8'd0;
        forever begin
            @(negedge clk);
            if (fact_go === 1'b1 && eng_on) begin
                n = int'(fact_n);
                repeat (eng_delay) @(negedge clk);
                fact_result = 8'(fact_of(4'(n)));
                fact_done   = 1'b1;
                @(negedge clk);
                fact_done   = 1'b0;
                fact_result = 8'd0;
            end
        end
    end

    // Monitor: every ack must match the next scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                check("ack_onehot", 32'($onehot(ack)), 32'd1);
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("ack_vector", 32'(ack), 32'd1 << e.id);
                    check("ack_grant_id", 32'(grant_id), 32'(e.id));
                    check("ack_result", 32'(result), 32'(e.res));
                    check("ack_err", 32'(err), 32'(e.er));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int go_cyc;
        int n_ack;
        rst       = 1'b1;
        req       = 4'b0;
        n_in      = 16'h0;
        eng_on    = 1'b1;
        eng_delay = 10;
        repeat (3) @(negedge clk);
        check("rst_fact_go", 32'(fact_go), 32'd0);
        check("rst_fact_n", 32'(fact_n), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // All four requesting: order 0,1,2,3,0.
        n_in      = {4'd5, 4'd4, 4'd3, 4'd2};
        eng_delay = 3;
        push(0, 2, 0);
        push(1, 6, 0);
        push(2, 24, 0);
        push(3, 120, 0);
        push(0, 2, 0);
        req   = 4'b1111;
        n_ack = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                n_ack++;
                if (n_ack == 5) begin
                    req = 4'b0;
                    break;
                end
            end
        end
        check("rr_ack_count", 32'(n_ack), 32'd5);
        repeat (3) @(negedge clk);
        check("rr_idle_busy", 32'(busy), 32'd0);

        // Single requester 2, n=5.
        n_in      = 16'h0500;
        eng_delay = 10;
        push(2, 120, 0);
        req = 4'b0100;
        @(negedge clk);
        go_cyc = cyc;
        check("t1_fact_go", 32'(fact_go), 32'd1);
        check("t1_fact_n", 32'(fact_n), 32'd5);
        check("t1_busy", 32'(busy), 32'd1);
        req = 4'b0;
        @(negedge clk);
        check("t1_go_one_cycle", 32'(fact_go), 32'd0);
        wait_ack(50, t);
        check("t1_ack_latency", 32'(t - go_cyc), 32'd11);
        repeat (2) @(negedge clk);

        // Requester 1 drops req and changes operand after grant.
        n_in      = 16'h0030;
        eng_delay = 5;
        push(1, 6, 0);
        req = 4'b0010;
        @(negedge clk);
        check("t6_fact_go", 32'(fact_go), 32'd1);
        check("t6_grant_id", 32'(grant_id), 32'd1);
        req  = 4'b0;
        n_in = 16'h0050;
        @(negedge clk);
        check("t6_fact_n_held", 32'(fact_n), 32'd3);
        wait_ack(50, t);
        repeat (2) @(negedge clk);

        // Silent engine: watchdog aborts exactly 256 cycles after fact_go.
        eng_on = 1'b0;
        n_in   = 16'h4000;
        push(3, 0, 1);
        req = 4'b1000;
        @(negedge clk);
        go_cyc = cyc;
        check("t3_fact_go", 32'(fact_go), 32'd1);
        req = 4'b0;
        wait_ack(400, t);
        check("t3_timeout_latency", 32'(t - go_cyc), 32'd256);
        @(negedge clk);
        fact_done   = 1'b1;
        fact_result = 8'h55;
        @(negedge clk);
        fact_done   = 1'b0;
        fact_result = 8'h00;
        repeat (3) @(negedge clk);
        check("t3_idle_done_busy", 32'(busy), 32'd0);
        check("t3_result_hold", 32'(result), 32'd0);
        check("t3_err_hold", 32'(err), 32'd1);

        // Done arrives on the very cycle the watchdog fires.
        eng_on    = 1'b1;
        eng_delay = 255;
        n_in      = 16'h0004;
        push(0, 24, 0);
        req = 4'b0001;
        @(negedge clk);
        go_cyc = cyc;
        check("t4_fact_go", 32'(fact_go), 32'd1);
        req = 4'b0;
        wait_ack(400, t);
        check("t4_ack_latency", 32'(t - go_cyc), 32'd256);
        repeat (2) @(negedge clk);

        // Reset during WAIT, late done ignored, arbitration restarts at 0.
        eng_delay = 20;
        n_in      = 16'h3000;
        req       = 4'b1000;
        @(negedge clk);
        check("t5_fact_go", 32'(fact_go), 32'd1);
        req = 4'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_fact_go", 32'(fact_go), 32'd0);
        check("t5_fact_n", 32'(fact_n), 32'd0);
        check("t5_grant_id", 32'(grant_id), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ack", 32'(ack), 32'd0);
        check("t5_result", 32'(result), 32'd0);
        check("t5_err", 32'(err), 32'd0);
        repeat (25) @(negedge clk);
        check("t5_late_done_busy", 32'(busy), 32'd0);
        n_in = 16'h2001;
        eng_delay = 4;
        push(0, 1, 0);
        req = 4'b1001;
        @(negedge clk);
        check("t5_restart_grant", 32'(grant_id), 32'd0);
        req = 4'b0;
        wait_ack(50, t);

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
